// File: rtl/spi_arb_if.sv
// Requester-side bundle of the spi arbiter: per-requester request/byte handshake
// plus the shared rx byte. The requesters are the master, the arbiter the slave.
interface spi_arb_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0][1:0]  dev;
    logic [NREQ-1:0][7:0]  len;
    logic [NREQ-1:0][7:0]  tx_data;
    logic [NREQ-1:0]       tx_take;
    logic [7:0]            rx_data;
    logic [NREQ-1:0]       rx_valid;
    logic [NREQ-1:0]       done;
    logic [NREQ-1:0]       err;
    logic [NREQ-1:0]       grant;

    modport master (
        output req, dev, len, tx_data,
        input  tx_take, rx_data, rx_valid, done, err, grant
    );

    modport slave (
        input  req, dev, len, tx_data,
        output tx_take, rx_data, rx_valid, done, err, grant
    );
endinterface

// File: rtl/spi_arb.sv
// Round-robin arbiter and byte sequencer sharing one spi controller register port
// between NREQ requesters; each granted requester runs a len+1 byte transaction.
module spi_arb #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       reset,
    spi_arb_if.slave   rq,
    output logic [2:0] spi_addr_o,
    output logic [7:0] spi_wdata_o,
    output logic [1:0] spi_sel_o,
    output logic       spi_read_o,
    output logic       spi_write_o,
    input  logic [7:0] spi_rdata_i,
    input  logic       spi_int_i
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = IW + 1;
    localparam int unsigned TW = 12;
    localparam int unsigned BW = 8;
    localparam int unsigned AW = 3;

    localparam logic [AW-1:0] ADDR_CTRL = AW'(0);
    localparam logic [AW-1:0] ADDR_DATA = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_XFER,
        S_NEXT,
        S_ABORT
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   g_q;
    logic [IW-1:0]   rr_q;
    logic [BW-1:0]   cnt_q;
    logic [TW-1:0]   tmo_q;
    logic [AW-1:0]   addr_q;
    logic [BW-1:0]   wdata_q;
    logic [1:0]      sel_q;
    logic            read_q;
    logic            write_q;
    logic [NREQ-1:0] take_q;
    logic [NREQ-1:0] rxv_q;
    logic [NREQ-1:0] done_q;
    logic [NREQ-1:0] err_q;
    logic [NREQ-1:0] grant_q;

    // First requester at or after the round-robin pointer, wrapping.
    logic            pick_found_c;
    logic [IW-1:0]   pick_idx_c;
    logic [CW-1:0]   cand_c;

    always_comb begin
        pick_found_c = 1'b0;
        pick_idx_c   = rr_q;
        cand_c       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand_c = CW'(rr_q) + CW'(i);
            if (cand_c >= CW'(NREQ)) begin
                cand_c = cand_c - CW'(NREQ);
            end
            if (!pick_found_c && rq.req[IW'(cand_c)]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = IW'(cand_c);
            end
        end
    end

    logic [NREQ-1:0] pick_oh_c;
    logic [NREQ-1:0] g_oh_c;
    logic [IW-1:0]   rr_next_c;
    logic [TW-1:0]   tmo_inc_c;
    logic            tmo_hit_c;

    assign pick_oh_c = NREQ'(1) << pick_idx_c;
    assign g_oh_c    = NREQ'(1) << g_q;
    assign rr_next_c = (g_q == IW'(NREQ - 1)) ? '0 : g_q + IW'(1);
    assign tmo_inc_c = tmo_q + TW'(1);
    assign tmo_hit_c = (tmo_inc_c == TW'(TIMEOUT));

    // Outputs are registered for the state being entered, so each pulse lines up
    // with the cycle the FSM spends in that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            take_q  <= '0;
            rxv_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            grant_q <= '0;
        end else begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            take_q  <= '0;
            rxv_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;

            case (state_q)
                S_IDLE: begin
                    if (pick_found_c) begin
                        g_q     <= pick_idx_c;
                        sel_q   <= rq.dev[pick_idx_c];
                        cnt_q   <= rq.len[pick_idx_c];
                        grant_q <= pick_oh_c;
                        write_q <= 1'b1;
                        addr_q  <= ADDR_CTRL;
                        wdata_q <= rq.tx_data[pick_idx_c];
                        take_q  <= pick_oh_c;
                        state_q <= S_START;
                    end
                end

                S_START: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    if (spi_int_i) begin
                        read_q  <= 1'b1;
                        rxv_q   <= g_oh_c;
                        if (cnt_q == '0) begin
                            addr_q <= ADDR_CTRL;
                            done_q <= g_oh_c;
                        end else begin
                            addr_q <= ADDR_DATA;
                        end
                        state_q <= S_XFER;
                    end else begin
                        tmo_q <= tmo_inc_c;
                        if (tmo_hit_c) begin
                            read_q  <= 1'b1;
                            addr_q  <= ADDR_CTRL;
                            err_q   <= g_oh_c;
                            state_q <= S_ABORT;
                        end
                    end
                end

                S_XFER: begin
                    if (cnt_q == '0) begin
                        grant_q <= '0;
                        rr_q    <= rr_next_c;
                        state_q <= S_IDLE;
                    end else begin
                        write_q <= 1'b1;
                        addr_q  <= ADDR_DATA;
                        wdata_q <= rq.tx_data[g_q];
                        take_q  <= g_oh_c;
                        state_q <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    cnt_q   <= cnt_q - BW'(1);
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end

                S_ABORT: begin
                    grant_q <= '0;
                    rr_q    <= rr_next_c;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign spi_addr_o  = addr_q;
    assign spi_wdata_o = wdata_q;
    assign spi_sel_o   = sel_q;
    assign spi_read_o  = read_q;
    assign spi_write_o = write_q;

    assign rq.tx_take  = take_q;
    assign rq.rx_valid = rxv_q;
    assign rq.done     = done_q;
    assign rq.err      = err_q;
    assign rq.grant    = grant_q;
    // Controller read data is combinational on the address, so it is forwarded
    // in the read cycle and zeroed whenever it is not qualified.
    assign rq.rx_data  = (|rxv_q) ? spi_rdata_i : '0;

    ap_rw_excl: assert property (@(posedge clk) disable iff (reset) !(read_q && write_q));
    ap_grant_oh: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));

endmodule

// File: tb/tb_spi_arb.sv
// Bench for spi_arb: a behavioural spi controller and requester byte sources,
// a table of single-requester transactions, and hand-written multi-cycle sequences.
module tb_spi_arb;

    localparam int unsigned NREQ = 2;
    localparam int unsigned TMO  = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_arb_if #(.NREQ(NREQ)) ifc ();

    logic [2:0] spi_addr;
    logic [7:0] spi_wdata;
    logic [7:0] spi_rdata;
    logic [1:0] spi_sel;
    logic       spi_read;
    logic       spi_write;
    logic       spi_int;

    spi_arb #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .rq         (ifc.slave),
        .spi_addr_o (spi_addr),
        .spi_wdata_o(spi_wdata),
        .spi_sel_o  (spi_sel),
        .spi_read_o (spi_read),
        .spi_write_o(spi_write),
        .spi_rdata_i(spi_rdata),
        .spi_int_i  (spi_int)
    );

    // Behavioural controller: returns written byte ^ 0x3C, interrupt after int_dly.
    int         int_dly;
    bit         int_en;
    logic       int_q, pend_q;
    logic [7:0] sh_q, rbyte_q;
    int         dly_q;

    always @(posedge clk) begin
        if (reset) begin
            int_q <= 1'b0; pend_q <= 1'b0; sh_q <= '0; rbyte_q <= '0; dly_q <= 0;
        end else if (spi_write) begin
            int_q <= 1'b0; pend_q <= 1'b1; dly_q <= int_dly; sh_q <= spi_wdata ^ 8'h3C;
        end else if (pend_q) begin
            if (dly_q == 0) begin
                int_q <= int_en; pend_q <= 1'b0; rbyte_q <= sh_q;
            end else begin
                dly_q <= dly_q - 1;
            end
        end
    end
    assign spi_int   = int_q;
    assign spi_rdata = rbyte_q;

    // Requester byte sources advance on tx_take.
    logic [7:0] tx_idx0, tx_idx1;
    always @(posedge clk) begin
        if (reset) begin
            tx_idx0 <= '0; tx_idx1 <= '0;
        end else begin
            if (ifc.tx_take[0]) tx_idx0 <= tx_idx0 + 8'd1;
            if (ifc.tx_take[1]) tx_idx1 <= tx_idx1 + 8'd1;
        end
    end
    assign ifc.tx_data = {8'h10 + tx_idx1, 8'hA5 + tx_idx0};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int i);
        logic [1:0] r;
        r = 2'b01 << i;
        return r;
    endfunction

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } sb_t;
    sb_t sb_q[$];

    logic [1:0] exp_dev [2];
    int viol = 0;
    int n_start = 0, n_next = 0, n_end = 0, n_done = 0, n_err = 0;
    int takes_n [2] = '{0, 0};
    int rxv_n   [2] = '{0, 0};
    int gi;
    sb_t e;

    // Monitor: scoreboard push on each byte write, pop on rx_valid / err.
    always @(negedge clk) begin
        if (!reset) begin
            gi = ifc.grant[1] ? 1 : 0;
            if (spi_read && spi_write) viol++;
            if (!$onehot0(ifc.grant)) viol++;
            if (spi_write) begin
                if (spi_addr == 3'd0) n_start++;
                else if (spi_addr == 3'd1) n_next++;
                else viol++;
                if (spi_sel != exp_dev[gi]) viol++;
                if (ifc.tx_take != ifc.grant) viol++;
                if (spi_wdata != ifc.tx_data[gi]) viol++;
                sb_q.push_back(sb_t'{gi[0], ifc.tx_data[gi] ^ 8'h3C});
            end else if (|ifc.tx_take) begin
                viol++;
            end
            if (spi_read && spi_addr == 3'd0) n_end++;
            if (|ifc.rx_valid) begin
                if (!spi_read) viol++;
                if (sb_q.size() == 0) begin
                    check("rx_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rx_data", 32'(ifc.rx_data), 32'(e.data));
                    check("rx_owner", 32'(ifc.rx_valid), 32'(oh(int'(e.id))));
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (ifc.tx_take[i]) takes_n[i]++;
                if (ifc.rx_valid[i]) rxv_n[i]++;
            end
            if (|ifc.done) begin
                n_done++;
                if (ifc.rx_valid != ifc.done || !spi_read || spi_addr != 3'd0 ||
                    ifc.grant != ifc.done) viol++;
            end
            if (|ifc.err) begin
                n_err++;
                if (!spi_read || spi_write || spi_addr != 3'd0 || (|ifc.rx_valid) ||
                    (|ifc.done) || ifc.grant != ifc.err) viol++;
                if (sb_q.size() == 0) begin
                    check("err_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("err_owner", 32'(ifc.err), 32'(oh(int'(e.id))));
                end
            end
        end
    end

    typedef struct {
        int         id;
        logic [1:0] dev;
        logic [7:0] len;
        int         dly;
        bit         drop;
        int         exp_bytes;
        int         exp_nexts;
        int         exp_done;
    } vec_t;

    int rr_m;

    task automatic run_txn(input vec_t v);
        int b_take, b_rxv, b_next, b_end, b_done, b_err, bound;
        bit seen;
        logic [7:0] first;
        b_take = takes_n[v.id]; b_rxv = rxv_n[v.id]; b_next = n_next;
        b_end = n_end; b_done = n_done; b_err = n_err;
        exp_dev[v.id]     = v.dev;
        ifc.dev[v.id]     = v.dev;
        ifc.len[v.id]     = v.len;
        int_dly           = v.dly;
        first             = ifc.tx_data[v.id];
        ifc.req[v.id]     = 1'b1;
        @(negedge clk);
        check("start_grant", 32'(ifc.grant), 32'(oh(v.id)));
        check("start_bus", 32'({spi_write, spi_read, spi_addr}), 32'(5'b10_000));
        check("start_sel", 32'(spi_sel), 32'(v.dev));
        check("start_wdata", 32'(spi_wdata), 32'(first));
        if (v.drop) ifc.req[v.id] = 1'b0;
        ifc.dev[v.id] = ~v.dev;
        ifc.len[v.id] = ~v.len;
        bound = (int'(v.len) + 1) * (v.dly + 8) + 40;
        seen  = 1'b0;
        for (int k = 0; k < bound && !seen; k++) begin
            @(negedge clk);
            if (ifc.done[v.id] || ifc.err[v.id]) seen = 1'b1;
        end
        ifc.req[v.id] = 1'b0;
        check("txn_complete", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        check("txn_takes", 32'(takes_n[v.id] - b_take), 32'(v.exp_bytes));
        check("txn_rxv", 32'(rxv_n[v.id] - b_rxv), 32'(v.exp_bytes));
        check("txn_nexts", 32'(n_next - b_next), 32'(v.exp_nexts));
        check("txn_ends", 32'(n_end - b_end), 32'd1);
        check("txn_done", 32'(n_done - b_done), 32'(v.exp_done));
        check("txn_err", 32'(n_err - b_err), 32'd0);
        check("txn_idle_grant", 32'(ifc.grant), 32'd0);
        rr_m = (v.id + 1) % 2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(ifc.grant), 32'd0);
        check({tag, "_pulses"}, 32'({ifc.tx_take, ifc.rx_valid, ifc.done, ifc.err}), 32'd0);
        check({tag, "_spi"}, 32'({spi_addr, spi_wdata, spi_sel, spi_read, spi_write}), 32'd0);
        check({tag, "_rxdata"}, 32'(ifc.rx_data), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        vec_t v;
        int   exp_g, n, b_done, b_err, k;
        bit   seen;

        vecs[0] = '{0, 2'd1, 8'd0,   2, 1'b0, 1,   0,   1};
        vecs[1] = '{1, 2'd2, 8'd3,   1, 1'b0, 4,   3,   1};
        vecs[2] = '{0, 2'd0, 8'd1,   0, 1'b1, 2,   1,   1};
        vecs[3] = '{1, 2'd3, 8'd7,   3, 1'b1, 8,   7,   1};
        vecs[4] = '{0, 2'd2, 8'd255, 0, 1'b0, 256, 255, 1};

        reset = 1'b1; ifc.req = '0; ifc.dev = '0; ifc.len = '0;
        int_en = 1'b1; int_dly = 1; exp_dev[0] = 2'd0; exp_dev[1] = 2'd0; rr_m = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check("first_byte_src", 32'(ifc.tx_data[0]), 32'h0A5);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Both requesting continuously: strict alternation with one idle cycle.
        exp_dev[0] = 2'd1; exp_dev[1] = 2'd2;
        ifc.dev[0] = 2'd1; ifc.dev[1] = 2'd2; ifc.len = '0; int_dly = 1;
        exp_g = rr_m; b_done = n_done;
        ifc.req = 2'b11;
        @(negedge clk);
        check("rr_first", 32'(ifc.grant), 32'(oh(exp_g)));
        for (int t = 0; t < 4; t++) begin
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                if (|ifc.done) seen = 1'b1;
                else @(negedge clk);
            end
            check("rr_done", 32'(ifc.done), 32'(oh(exp_g)));
            if (t == 3) begin
                ifc.req = '0;
            end else begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (ifc.grant == '0 && n < 6);
                check("rr_gap", 32'(n), 32'd2);
                exp_g ^= 1;
                check("rr_grant", 32'(ifc.grant), 32'(oh(exp_g)));
            end
        end
        repeat (3) @(negedge clk);
        check("rr_done_count", 32'(n_done - b_done), 32'd4);
        rr_m = (exp_g + 1) % 2;

        // Interrupt never arrives: abort 16 cycles after the start write.
        int_en = 1'b0; exp_dev[0] = 2'd1; ifc.dev[0] = 2'd1; ifc.len[0] = 8'd2;
        b_done = n_done; b_err = n_err;
        ifc.req[0] = 1'b1;
        @(negedge clk);
        check("tmo_start", 32'({spi_write, spi_addr}), 32'(4'b1_000));
        k = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (ifc.err[0]) seen = 1'b1;
        end
        check("tmo_cycles", 32'(k), 32'd16);
        check("tmo_bus", 32'({spi_read, spi_write, spi_addr}), 32'(5'b10_000));
        check("tmo_no_rxv", 32'(ifc.rx_valid), 32'd0);
        ifc.req[0] = 1'b0; int_en = 1'b1;
        repeat (3) @(negedge clk);
        check("tmo_err_count", 32'(n_err - b_err), 32'd1);
        check("tmo_no_done", 32'(n_done - b_done), 32'd0);
        rr_m = 1;
        v = '{1, 2'd1, 8'd2, 1, 1'b0, 3, 2, 1};
        run_txn(v);

        // Reset in WAIT during a 6-byte transaction.
        exp_dev[1] = 2'd2; ifc.dev[1] = 2'd2; ifc.len[1] = 8'd5; int_dly = 10;
        ifc.req[1] = 1'b1;
        @(negedge clk);
        check("rst_txn_start", 32'(ifc.grant), 32'(oh(1)));
        @(negedge clk);
        reset = 1'b1;
        ifc.req[1] = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        reset = 1'b0;
        sb_q.delete();
        rr_m = 0;
        v = '{1, 2'd3, 8'd5, 2, 1'b0, 6, 5, 1};
        run_txn(v);

        check("invariants", 32'(viol), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
